// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier driving an external add_sub unit.
// Define BOOTH_SKIP_EN to fold the shift into CALC for 00/11 bit pairs.
module booth_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   as_a,
  output logic [WIDTH-1:0]   as_b,
  output logic               as_m,
  input  logic [WIDTH-1:0]   as_s,
  input  logic               as_c
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic               q_1;
  logic [WIDTH-1:0]   mc;
  logic [CW-1:0]      cnt;
  logic               err_r;
  logic               err_q;
  logic [2*WIDTH-1:0] prod_r;

  logic [1:0]         pair;
  logic               op_en;
  logic               last;
  logic               load;
  logic               acc_ld;
  logic               shift_en;
  logic [2*WIDTH:0]   shr;
  logic               as_c_unused;

  // Carry-out is meaningless for two's-complement accumulation.
  assign as_c_unused = as_c;

  assign pair  = {q[0], q_1};
  assign op_en = ^pair;
  assign last  = (cnt == CW'(1));
  assign shr   = {acc[WIDTH-1], acc, q};

  assign load   = (state == S_IDLE) && start;
  assign acc_ld = (state == S_CALC) && op_en;

  always_comb begin
    shift_en = (state == S_SHIFT);
`ifdef BOOTH_SKIP_EN
    if ((state == S_CALC) && !op_en)
      shift_en = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          nstate = S_CALC;
      end
      S_CALC: begin
        nstate = S_SHIFT;
`ifdef BOOTH_SKIP_EN
        if (!op_en)
          nstate = last ? S_DONE : S_CALC;
`endif
      end
      S_SHIFT: begin
        nstate = last ? S_DONE : S_CALC;
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    as_m = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_CALC:  as_m = (pair == 2'b10);
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: ACC/Q/Q_1 form one arithmetic shift chain
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      mc     <= '0;
      cnt    <= '0;
      err_r  <= 1'b0;
      err_q  <= 1'b0;
      prod_r <= '0;
    end else if (load) begin
      mc    <= mcand;
      q     <= mplier;
      acc   <= '0;
      q_1   <= 1'b0;
      cnt   <= CW'(WIDTH);
      err_r <= (mcand == {1'b1, {(WIDTH-1){1'b0}}});
    end else if (acc_ld) begin
      acc <= as_s;
    end else if (shift_en) begin
      {acc, q, q_1} <= shr;
      cnt <= cnt - CW'(1);
      if (last) begin
        prod_r <= shr[2*WIDTH:1];
        err_q  <= err_r;
      end
    end
  end

  assign as_a    = acc;
  assign as_b    = mc;
  assign product = prod_r;
  assign err     = err_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a behavioural add_sub model.
// Latency expectations follow BOOTH_SKIP_EN when it is defined.
module tb_booth_mul_seq;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] product;
  logic [W-1:0]   as_a;
  logic [W-1:0]   as_b;
  logic           as_m;
  logic [W-1:0]   as_s;
  logic           as_c;
  logic [W:0]     sum;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .product (product),
    .as_a    (as_a),
    .as_b    (as_b),
    .as_m    (as_m),
    .as_s    (as_s),
    .as_c    (as_c)
  );

  // add_sub: S = A + B (M=0) or A - B (M=1)
  always_comb begin
    sum  = {1'b0, as_a} + {1'b0, (as_m ? ~as_b : as_b)}
         + {{W{1'b0}}, as_m};
    as_s = sum[W-1:0];
    as_c = sum[W];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0]   mc,
                        input logic [W-1:0]   mp,
                        input logic [2*W-1:0] xp,
                        input logic           xe,
                        input bit             cp,
                        input int             lb,
                        input int             ls);
    int n;
    int xl;
`ifdef BOOTH_SKIP_EN
    xl = ls;
`else
    xl = lb;
`endif
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    n = 1;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, xl);
    if (cp)
      check("product", product, xp);
    check("err", err, xe);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    if (cp)
      check("product_held", product, xp);
  endtask

  initial begin
    int ndone;
    logic [2*W-1:0] pseen;

    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    check("rst_as_m", as_m, 0);
    rst = 1'b0;

    run_op(4'h3, 4'hE, 8'hFA, 1'b0, 1'b1, 9, 6);
    run_op(4'h9, 4'h7, 8'hCF, 1'b0, 1'b1, 9, 7);
    run_op(4'h5, 4'h8, 8'hD8, 1'b0, 1'b1, 9, 6);
    run_op(4'hF, 4'h8, 8'h08, 1'b0, 1'b1, 9, 6);
    run_op(4'hF, 4'hF, 8'h01, 1'b0, 1'b1, 9, 6);
    run_op(4'h7, 4'h8, 8'hC8, 1'b0, 1'b1, 9, 6);
    run_op(4'h9, 4'h8, 8'h38, 1'b0, 1'b1, 9, 6);
    run_op(4'h3, 4'h0, 8'h00, 1'b0, 1'b1, 9, 5);
    run_op(4'h3, 4'h5, 8'h0F, 1'b0, 1'b1, 9, 9);

    // start held high, operands changed mid-run
    @(negedge clk);
    mcand  = 4'h3;
    mplier = 4'hE;
    start  = 1'b1;
    @(posedge clk);
    ndone = 0;
    pseen = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check("held_busy", busy, 1);
        mcand  = 4'h5;
        mplier = 4'h5;
      end
      if (done) begin
        ndone++;
        pseen = product;
        start = 1'b0;
      end
    end
    check("held_one_done", ndone, 1);
    check("held_product", pseen, 8'hFA);

    run_op(4'h8, 4'h3, 8'h00, 1'b1, 1'b0, 9, 7);

    // reset pulsed in cycle 4 of a run
    @(negedge clk);
    mcand  = 4'h3;
    mplier = 4'h5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_prod", product, 0);
    check("mrst_as_m", as_m, 0);
    check("mrst_as_a", as_a, 0);
    check("mrst_as_b", as_b, 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done)
        ndone++;
    end
    check("mrst_no_done", ndone, 0);

    run_op(4'h1, 4'h1, 8'h01, 1'b0, 1'b1, 9, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
